// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN pixel-stream stages (convolution -> pooling).
// Provides the default pixel width, the default frame geometry and a pure
// unsigned max helper. The helper works on a wide container type so stages
// with any WORD_SIZE up to MAX_PIXEL_WIDTH can zero-extend into it and
// truncate the result back.
package cnn_stream_pkg;

  localparam int unsigned PIXEL_WIDTH          = 8;
  localparam int unsigned MAX_PIXEL_WIDTH      = 32;
  localparam int unsigned DEFAULT_ROW_SIZE     = 540;
  localparam int unsigned DEFAULT_IMAGE_HEIGHT = 360;

  typedef logic [PIXEL_WIDTH-1:0]     pixel_t;
  typedef logic [MAX_PIXEL_WIDTH-1:0] wide_pixel_t;

  // Unsigned maximum; ties return the common value.
  function automatic wide_pixel_t pixel_max(input wide_pixel_t a, input wide_pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Simple dual-port line buffer for the pooling stage: one write port, one
// read port, synchronous read, no reset on the storage so it maps onto
// block RAM.
// Ports:
//   clk      - clock, all activity on posedge
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every posedge
//   rd_data  - registered read data (mem[rd_addr] from the previous edge)
module pool_row_buffer #(
  parameter int unsigned DEPTH  = 270,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max-pool stage fed by the convolution's raster
// pixel stream (no backpressure). Even-row pairs are reduced horizontally
// and parked in a half-width line buffer; odd-row pairs are reduced and
// combined with the parked value to produce one pooled pixel.
// Ports:
//   clk         - clock, all logic on posedge
//   rst         - asynchronous active-high reset
//   inputPixel  - pixel from the convolution stage
//   inputValid  - inputPixel valid this cycle
//   outputPixel - pooled pixel (holds while outputValid is low)
//   outputValid - single-cycle pulse per pooled pixel
//   frameDone   - pulses with the last pooled pixel of a frame
module max_pool_2x2
  import cnn_stream_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = PIXEL_WIDTH,
  parameter int unsigned ROW_SIZE     = DEFAULT_ROW_SIZE,
  parameter int unsigned IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  input  logic                 inputValid,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic                 outputValid,
  output logic                 frameDone
);

  localparam int unsigned COL_W     = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned ROW_W     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned BUF_DEPTH = ROW_SIZE / 2;
  localparam int unsigned BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

  if ((ROW_SIZE % 2) != 0) begin : g_bad_row_size
    $error("max_pool_2x2: ROW_SIZE must be even");
  end
  if ((IMAGE_HEIGHT % 2) != 0) begin : g_bad_image_height
    $error("max_pool_2x2: IMAGE_HEIGHT must be even");
  end
  if (WORD_SIZE > MAX_PIXEL_WIDTH) begin : g_bad_word_size
    $error("max_pool_2x2: WORD_SIZE exceeds MAX_PIXEL_WIDTH");
  end

  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [WORD_SIZE-1:0] pair_q, pair_d;
  logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_done_q, frame_done_d;

  logic [BUF_AW-1:0]    buf_addr;
  logic                 buf_wr_en;
  logic [WORD_SIZE-1:0] buf_rd_data;
  logic [WORD_SIZE-1:0] hmax;
  logic [WORD_SIZE-1:0] pool_max;

  // Read and write share col>>1. The address is already correct one cycle
  // before the even pixel of a pair is accepted (col and col+1 map to the
  // same slot), so the registered read data is valid by the odd pixel.
  assign buf_addr = BUF_AW'(col_q >> 1);

  assign hmax     = WORD_SIZE'(pixel_max(MAX_PIXEL_WIDTH'(pair_q),
                                         MAX_PIXEL_WIDTH'(inputPixel)));
  assign pool_max = WORD_SIZE'(pixel_max(MAX_PIXEL_WIDTH'(hmax),
                                         MAX_PIXEL_WIDTH'(buf_rd_data)));

  pool_row_buffer #(
    .DEPTH  (BUF_DEPTH),
    .WIDTH  (WORD_SIZE),
    .ADDR_W (BUF_AW)
  ) u_row_buffer (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_addr),
    .wr_data (hmax),
    .rd_addr (buf_addr),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    out_pixel_d  = out_pixel_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    buf_wr_en    = 1'b0;

    if (inputValid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0]) begin
        pair_d = inputPixel;
      end else if (!row_q[0]) begin
        buf_wr_en = 1'b1;
      end else begin
        out_pixel_d  = pool_max;
        out_valid_d  = 1'b1;
        frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_pixel_q  <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_pixel_q  <= out_pixel_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign outputPixel = out_pixel_q;
  assign outputValid = out_valid_q;
  assign frameDone   = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
module tb_max_pool_2x2;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] in_pixel;
  logic in_valid;
  int sel;
  int cyc = 0;
  int last_acc;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic v0, v1, v2, v3;
  assign v0 = in_valid && (sel == 0);
  assign v1 = in_valid && (sel == 1);
  assign v2 = in_valid && (sel == 2);
  assign v3 = in_valid && (sel == 3);

  logic [7:0] op0, op1, op2, op3;
  logic ov0, ov1, ov2, ov3, fd0, fd1, fd2, fd3;

  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4), .IMAGE_HEIGHT(2)) u_4x2 (
    .clk(clk), .rst(rst), .inputPixel(in_pixel), .inputValid(v0),
    .outputPixel(op0), .outputValid(ov0), .frameDone(fd0));
  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4), .IMAGE_HEIGHT(4)) u_4x4 (
    .clk(clk), .rst(rst), .inputPixel(in_pixel), .inputValid(v1),
    .outputPixel(op1), .outputValid(ov1), .frameDone(fd1));
  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(20), .IMAGE_HEIGHT(6)) u_mid (
    .clk(clk), .rst(rst), .inputPixel(in_pixel), .inputValid(v2),
    .outputPixel(op2), .outputValid(ov2), .frameDone(fd2));
  max_pool_2x2 u_big (
    .clk(clk), .rst(rst), .inputPixel(in_pixel), .inputValid(v3),
    .outputPixel(op3), .outputValid(ov3), .frameDone(fd3));

  typedef struct {
    logic [7:0] pix;
    logic       fd;
    int         cyc;
  } obs_t;

  obs_t obs0[$], obs1[$], obs2[$], obs3[$], got[$];

  always @(negedge clk) begin
    if (ov0 === 1'b1) obs0.push_back('{op0, fd0, cyc});
    if (ov1 === 1'b1) obs1.push_back('{op1, fd1, cyc});
    if (ov2 === 1'b1) obs2.push_back('{op2, fd2, cyc});
    if (ov3 === 1'b1) obs3.push_back('{op3, fd3, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs(input int s);
    case (s)
      0: obs0.delete();
      1: obs1.delete();
      2: obs2.delete();
      default: obs3.delete();
    endcase
  endtask

  task automatic fetch_obs(input int s);
    case (s)
      0: got = obs0;
      1: got = obs1;
      2: got = obs2;
      default: got = obs3;
    endcase
  endtask

  // Present one pixel for one accepting edge, then idle 'gap' cycles with
  // junk on the data bus. Inputs change 1 ns after posedge.
  task automatic send(input logic [7:0] p, input int gap);
    in_pixel = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    last_acc = cyc;
    in_valid = 1'b0;
    in_pixel = 8'($urandom);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < n; g++) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int         sel;
    int         rows;
    int         cols;
    int         gap;
    logic [7:0] px [16];
    int         nexp;
    logic [7:0] ex [4];
  } vec_t;

  vec_t tbl [4];

  // Pooled pixel k must be seen in the cycle directly after the input cycle
  // of its 4th pixel; frameDone only on the last pooled pixel of the frame.
  task automatic run_vec(input vec_t v, input int idx);
    int exp_cyc[$];
    clear_obs(v.sel);
    sel = v.sel;
    for (int i = 0; i < v.rows * v.cols; i++) begin
      send(v.px[i], v.gap);
      if (((i / v.cols) % 2 == 1) && ((i % v.cols) % 2 == 1)) exp_cyc.push_back(last_acc);
    end
    idle(3);
    fetch_obs(v.sel);
    check($sformatf("vec%0d_count", idx), got.size(), v.nexp);
    for (int k = 0; k < v.nexp && k < got.size(); k++) begin
      check($sformatf("vec%0d_pix%0d", idx, k), got[k].pix, v.ex[k]);
      check($sformatf("vec%0d_fd%0d", idx, k), got[k].fd, (k == v.nexp - 1) ? 1 : 0);
      check($sformatf("vec%0d_lat%0d", idx, k), got[k].cyc, exp_cyc[k]);
    end
  endtask

  logic [7:0] img [6][540];

  // Reference: each pooled pixel is the max of its 2x2 block, computed
  // directly over a stored image, raster order of blocks.
  task automatic random_run(input int s, input int w, input int rows_sent, input int h_frame,
                            input int frames, input int max_gap, input string tag);
    logic [8:0] expq[$];
    logic [7:0] m;
    clear_obs(s);
    sel = s;
    for (int f = 0; f < frames; f++) begin
      for (int r = 0; r < rows_sent; r++)
        for (int c = 0; c < w; c++) img[r][c] = 8'($urandom);
      for (int br = 0; br < rows_sent / 2; br++)
        for (int bc = 0; bc < w / 2; bc++) begin
          m = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (img[2*br+dr][2*bc+dc] > m) m = img[2*br+dr][2*bc+dc];
          expq.push_back({((2*br + 2 == h_frame) && (bc == w/2 - 1)) ? 1'b1 : 1'b0, m});
        end
      for (int r = 0; r < rows_sent; r++)
        for (int c = 0; c < w; c++)
          send(img[r][c], ($urandom_range(0, 3) == 0) ? $urandom_range(0, max_gap) : 0);
    end
    idle(3);
    fetch_obs(s);
    check({tag, "_count"}, got.size(), expq.size());
    for (int k = 0; k < expq.size() && k < got.size(); k++) begin
      check($sformatf("%s_pix%0d", tag, k), got[k].pix, expq[k][7:0]);
      check($sformatf("%s_fd%0d", tag, k), got[k].fd, expq[k][8]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 2, 4, 0, '{1,2,3,4,5,6,7,8,0,0,0,0,0,0,0,0}, 2, '{6,8,0,0}};
    tbl[1] = '{0, 2, 4, 3, '{1,2,3,4,5,6,7,8,0,0,0,0,0,0,0,0}, 2, '{6,8,0,0}};
    tbl[2] = '{1, 4, 4, 0, '{9,0,0,0,0,0,0,7,0,0,255,0,0,3,0,0}, 4, '{9,7,3,255}};
    tbl[3] = '{1, 4, 4, 1, '{128,128,128,128,128,128,128,128,128,128,128,128,128,128,128,128},
               4, '{128,128,128,128}};

    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    sel = 0;
    #7;
    check("rst_op0", op0, 0); check("rst_ov0", ov0, 0); check("rst_fd0", fd0, 0);
    check("rst_op1", op1, 0); check("rst_ov1", ov1, 0); check("rst_fd1", fd1, 0);
    check("rst_op3", op3, 0); check("rst_ov3", ov3, 0); check("rst_fd3", fd3, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      run_vec(tbl[i], i);
      if (i == 0) begin
        check("hold_pix", op0, 8);
        check("hold_valid", ov0, 0);
      end
    end

    // Two 4x4 frames of 0x80 with no idle cycle between them.
    clear_obs(1);
    sel = 1;
    for (int i = 0; i < 32; i++) send(8'h80, 0);
    idle(3);
    fetch_obs(1);
    check("b2b_count", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      check($sformatf("b2b_pix%0d", k), got[k].pix, 8'h80);
      check($sformatf("b2b_fd%0d", k), got[k].fd, (k % 4 == 3) ? 1 : 0);
    end

    // Abort a 4x2 frame mid-way; the pooled pixel produced by the last
    // accepted pixel is cut off by the asynchronous reset.
    clear_obs(0);
    sel = 0;
    send(200, 0); send(201, 0); send(202, 0); send(203, 0);
    send(210, 0); send(211, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ov", ov0, 0);
    check("midrst_op", op0, 0);
    check("midrst_fd", fd0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    check("midrst_no_output", obs0.size(), 0);
    run_vec(tbl[0], 10);

    random_run(2, 20, 6, 6, 2, 3, "mid");
    random_run(3, 540, 6, 360, 1, 0, "big");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
